// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: DATA_BITS payload sent LSB first, run-time parity and stop-bit
// selection latched per frame, bit timing from an external baud tick with OVERSAMPLE ticks per bit.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_CNT_W = 6
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Tick,
  input  logic                 TxStart,
  input  logic [DATA_BITS-1:0] DataIn,
  input  logic [1:0]           ParityMode,
  input  logic                 TwoStop,
  output logic                 Tx,
  output logic                 TxReady,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam int BIT_CNT_W = 4;
  localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state, state_next;
  logic [TICK_CNT_W-1:0]  tick_cnt, tick_next;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_next;
  logic [DATA_BITS-1:0]   shreg, shreg_next;
  logic                   par_bit, par_bit_next;
  logic                   par_en, par_en_next;
  logic                   two_stop, two_stop_next;
  logic                   tx_q, tx_next;
  logic                   done_q, done_next;
  logic                   bit_end;

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next    = state;
    tick_next     = tick_cnt;
    bit_next      = bit_cnt;
    shreg_next    = shreg;
    par_bit_next  = par_bit;
    par_en_next   = par_en;
    two_stop_next = two_stop;
    done_next     = 1'b0;
    bit_end       = Tick && (tick_cnt == TICK_LAST);

    if (state != S_IDLE && Tick) begin
      tick_next = bit_end ? '0 : tick_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (TxStart) begin
          shreg_next    = DataIn;
          par_bit_next  = (ParityMode == 2'b10) ? ~(^DataIn) : ^DataIn;
          par_en_next   = (ParityMode == 2'b01) || (ParityMode == 2'b10);
          two_stop_next = TwoStop;
          tick_next     = '0;
          bit_next      = '0;
          state_next    = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_next   = '0;
            state_next = par_en ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        // bit_cnt is reused to count the optional second stop bit
        if (bit_end) begin
          if (two_stop && bit_cnt == '0) begin
            bit_next = 1;
          end else begin
            bit_next   = '0;
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tick_next  = '0;
        bit_next   = '0;
      end
    endcase

    // The line is registered, so it is driven from the bit about to become current.
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shreg_next[0];
      S_PARITY: tx_next = par_bit_next;
      default:  tx_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      two_stop <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      par_bit  <= par_bit_next;
      par_en   <= par_en_next;
      two_stop <= two_stop_next;
      tx_q     <= tx_next;
      done_q   <= done_next;
    end
  end

  assign Tx      = tx_q;
  assign TxDone  = done_q;
  assign TxReady = (state == S_IDLE);
  assign TxBusy  = ~TxReady;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three instances (8b/OS4, 8b/OS16, 7b/OS4) checked cycle by cycle
// against an expected bit list built from the frame format.
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [2:0] start_v;
  logic [7:0] data_in;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic [2:0] tx_v, rdy_v, busy_v, done_v;

  int total = 0;
  int bad   = 0;
  int tick_period = 1;
  int tick_ph = 0;

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(4), .TICK_CNT_W(6)) dut_a (
    .Clock(clk), .ResetN(rst_n), .Tick(tick), .TxStart(start_v[0]), .DataIn(data_in),
    .ParityMode(parity_mode), .TwoStop(two_stop),
    .Tx(tx_v[0]), .TxReady(rdy_v[0]), .TxBusy(busy_v[0]), .TxDone(done_v[0]));

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .TICK_CNT_W(6)) dut_b (
    .Clock(clk), .ResetN(rst_n), .Tick(tick), .TxStart(start_v[1]), .DataIn(data_in),
    .ParityMode(parity_mode), .TwoStop(two_stop),
    .Tx(tx_v[1]), .TxReady(rdy_v[1]), .TxBusy(busy_v[1]), .TxDone(done_v[1]));

  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(4), .TICK_CNT_W(6)) dut_c (
    .Clock(clk), .ResetN(rst_n), .Tick(tick), .TxStart(start_v[2]), .DataIn(data_in[6:0]),
    .ParityMode(parity_mode), .TwoStop(two_stop),
    .Tx(tx_v[2]), .TxReady(rdy_v[2]), .TxBusy(busy_v[2]), .TxDone(done_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick: high for one cycle out of every tick_period cycles, changed just after the edge.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_ph = (tick_ph + 1) % tick_period;
      tick    = (tick_ph == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_tx"},   tx_v[sel],   1);
    check({tag, "_rdy"},  rdy_v[sel],  1);
    check({tag, "_busy"}, busy_v[sel], 0);
    check({tag, "_done"}, done_v[sel], 0);
  endtask

  // Sends one frame on instance sel and checks every cycle of it.
  //   hold  : keep TxStart high so the next frame is accepted on the TxDone cycle
  //   pre   : frame was already accepted by a held TxStart on the previous TxDone cycle
  //   pulse : pulse TxStart once while busy (must be ignored)
  //   abort : reset when bit index abort_idx is on the line (-1 = never)
  task automatic send_frame(input int sel, input logic [7:0] data, input logic [1:0] pm,
                            input logic two, input bit hold, input logic [7:0] next_data,
                            input bit pre, input bit pulse, input int abort_idx);
    bit q[$];
    bit parity;
    int db, os, nb, ticks, c, idx;
    db = (sel == 2) ? 7 : 8;
    os = (sel == 1) ? 16 : 4;
    parity = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      q.push_back(data[i]);
      parity ^= data[i];
    end
    if (pm == 2'b01) q.push_back(parity);
    else if (pm == 2'b10) q.push_back(!parity);
    q.push_back(1'b1);
    if (two) q.push_back(1'b1);
    nb = q.size();

    if (!pre) begin
      c = 0;
      while (rdy_v[sel] !== 1'b1 && c < 100) begin
        @(negedge clk);
        c++;
      end
      check("ready_before_start", rdy_v[sel], 1);
      @(negedge clk);
      data_in     = data;
      parity_mode = pm;
      two_stop    = two;
      start_v[sel] = 1'b1;
    end
    @(posedge clk);
    ticks = 0;
    c = 0;
    while (1) begin
      @(negedge clk);
      if (c == 0 && !hold) start_v[sel] = 1'b0;
      idx = ticks / os;
      if (idx >= nb) break;
      check($sformatf("tx_bit%0d", idx), tx_v[sel], q[idx]);
      check("rdy_in_frame",  rdy_v[sel],  0);
      check("busy_in_frame", busy_v[sel], 1);
      check("done_in_frame", done_v[sel], 0);
      if (idx == abort_idx) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle(sel, "after_abort");
        rst_n = 1'b1;
        return;
      end
      if (c == 10) begin
        data_in = next_data;
        if (!hold) begin
          parity_mode = ~pm;
          two_stop    = ~two;
        end
        if (pulse) start_v[sel] = 1'b1;
      end else if (c == 11 && pulse) begin
        start_v[sel] = 1'b0;
      end
      @(posedge clk);
      if (tick === 1'b1) ticks++;
      c++;
      if (c > 20000) begin
        total++;
        assert (c <= 20000) else begin
          bad++;
          $error("FAIL frame_timeout observed=%0d expected<=%0d", c, 20000);
        end
        return;
      end
    end
    check("end_tx",   tx_v[sel],   1);
    check("end_rdy",  rdy_v[sel],  1);
    check("end_busy", busy_v[sel], 0);
    check("end_done", done_v[sel], 1);
    if (tick_period == 1) check("frame_cycles", c, os * nb);
    if (!hold) begin
      @(negedge clk);
      check_idle(sel, "post_frame");
    end
  endtask

  initial begin
    logic [7:0] d;
    rst_n       = 1'b0;
    start_v     = '0;
    data_in     = '0;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) check_idle(s, "reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 on OS=4 with a tick every cycle
    tick_period = 1;
    send_frame(0, 8'hA5, 2'b00, 1'b0, 0, 8'h5A, 0, 0, -1);
    // even then odd parity, two stop bits
    send_frame(0, 8'hA5, 2'b01, 1'b1, 0, 8'h00, 0, 0, -1);
    send_frame(0, 8'hA5, 2'b10, 1'b1, 0, 8'hFF, 0, 0, -1);
    // slow tick, OS=16
    tick_period = 5;
    send_frame(1, 8'h00, 2'b00, 1'b0, 0, 8'hFF, 0, 0, -1);
    // back-to-back frames with TxStart held and DataIn changed mid-frame
    tick_period = 1;
    send_frame(0, 8'h3C, 2'b00, 1'b0, 1, 8'hC3, 0, 0, -1);
    send_frame(0, 8'hC3, 2'b00, 1'b0, 0, 8'h11, 1, 0, -1);
    // reset during DATA bit 3, then a clean frame
    d = 8'($urandom);
    send_frame(0, d, 2'b01, 1'b0, 0, 8'h00, 0, 0, 4);
    @(negedge clk);
    check_idle(0, "idle_after_abort");
    d = 8'($urandom);
    send_frame(0, d, 2'b10, 1'b0, 0, 8'h00, 0, 0, -1);
    // 7-bit instance, reserved parity mode, TxStart pulsed while busy
    send_frame(2, 8'h5B, 2'b11, 1'b0, 0, 8'h24, 0, 1, -1);
    repeat (4) begin
      @(negedge clk);
      check("no_queued_frame_tx",  tx_v[2],  1);
      check("no_queued_frame_rdy", rdy_v[2], 1);
    end
    // randomized frames
    for (int k = 0; k < 6; k++) begin
      tick_period = $urandom_range(1, 3);
      send_frame((k % 2 == 0) ? 0 : 2, 8'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 0, 8'($urandom), 0, (k == 3), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter and successor to the fixed 8N1 transmitter.
- Data width is set at build time.
- Parity (none/even/odd) and stop-bit count (1/2) are selectable at run time and latched per frame.
- Bit timing is driven by an external baud-tick enable from the baud rate generator, with a configurable oversampling factor.
- Sits between the TX FIFO/host logic and the serial pin, with a ready/start handshake and an end-of-frame pulse.

Parameters:
DATA_BITS, 8, number of data bits per frame, legal 5..9, sent LSB first
OVERSAMPLE, 16, Tick pulses per serial bit, legal 2..64
TICK_CNT_W, 6, width of the tick counter; must satisfy 2**TICK_CNT_W >= OVERSAMPLE

Ports:
Clock  input  1  system clock; all state updates on rising edge
ResetN  input  1  synchronous active-low reset, sampled on rising edge of Clock
Tick  input  1  one-Clock-cycle baud enable from the baud generator
TxStart  input  1  request to send; accepted only when TxReady=1
DataIn  input  DATA_BITS  frame payload, sampled on accept
ParityMode  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none); sampled on accept
TwoStop  input  1  0 = one stop bit, 1 = two stop bits; sampled on accept
Tx  output  1  serial line, registered, idles high
TxReady  output  1  high when in IDLE and able to accept TxStart
TxBusy  output  1  inverse of TxReady
TxDone  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (ResetN=0 at a rising edge): state IDLE, Tx=1, TxReady=1, TxBusy=0, TxDone=0, all counters 0, shift register 0. This applies even mid-frame; the line returns high on the next cycle and no TxDone is generated.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE with TxStart=1 at an edge:
  - latch DataIn, ParityMode, TwoStop;
  - compute the parity bit from the latched data: even = XOR of the data bits, odd = its inverse;
  - clear the tick and bit counters;
  - go to START. Tx=0 and TxReady=0 from the next cycle.
- Input changes during a frame have no effect. TxStart while busy is ignored, not queued.
- Bit timing:
  - Each non-IDLE state bit lasts exactly OVERSAMPLE Tick pulses.
  - The tick counter increments on each Clock edge with Tick=1.
  - On the edge where Tick=1 and the counter equals OVERSAMPLE-1, the counter clears and the bit advances.
  - Clock edges with Tick=0 hold all state. Tick is ignored in IDLE.
- Transitions:
  - START -> DATA.
  - DATA: shift out bit0, shift right, bit counter +1. After bit DATA_BITS-1, go to PARITY if parity is enabled, else STOP.
  - PARITY -> STOP.
  - STOP: 1 stop bit, or 2 stop bits when TwoStop=1. After the final stop bit, go to IDLE.
- Tx is registered and equals the value of the current bit: START 0, DATA shift-register bit0, PARITY the parity bit, STOP 1, IDLE 1.
- TxDone: registered. High for exactly the first cycle back in IDLE, the same cycle TxReady returns to 1.
- Back-to-back frames: TxStart held high is accepted on that TxDone cycle. The minimum idle gap is one Clock cycle, with Tx high.
- Frame length = OVERSAMPLE * (1 + DATA_BITS + P + S) Tick pulses, where P is 0 or 1 and S is 1 or 2.
- Illegal state encoding returns to IDLE with Tx=1.

Test Plan:
1. OVERSAMPLE=4, Tick every cycle, DataIn=8'hA5, ParityMode=00, TwoStop=0 -> Tx bits 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. TxDone pulses once, 40 cycles after Tx falls. TxReady is low throughout.
2. Same data with ParityMode=01 then 10, TwoStop=1 -> parity bit 0 (even) / 1 (odd). Two stop bits. 48 Tick pulses per frame.
3. Tick asserted every 5th cycle, OVERSAMPLE=16, DataIn=8'h00 -> each bit lasts 80 cycles. Tx low for 9 bits, then high.
4. TxStart held high across two frames (8'h3C then 8'hC3) -> second START begins exactly 1 cycle after TxDone. No bit lost. DataIn changed mid-frame does not corrupt the first frame.
5. ResetN=0 for one cycle during DATA bit 3 -> next cycle Tx=1, TxReady=1, TxDone=0. A new frame sent afterwards is correct.
6. DATA_BITS=7, ParityMode=11, TxStart pulsed while busy -> reserved mode gives a frame with no parity bit. The pulse while busy is ignored: only one frame is sent.
